// File: rtl/rattlesnake_load_store_unit_pkg.sv
// Shared types, funct3 codes and lane helpers for the
// rattlesnake load/store unit.
package rattlesnake_load_store_unit_pkg;

   localparam int XLEN_DEF          = 32;
   localparam int XLEN_BYTES        = XLEN_DEF / 8;
   localparam int MEM_ADDR_BITS_DEF = 16;
   localparam int STARVE_DEF        = 8;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE
   } ls_state_e;

   function automatic logic bad_req(
      input logic       ld,
      input logic       st,
      input logic [2:0] f3
   );
      if (ld && st) return 1'b1;
      if (ld) return (f3 == 3'd3) || (f3[2:1] == 2'b11);
      return f3 > F3_SW;
   endfunction

   function automatic logic misaligned(
      input logic [2:0] f3,
      input logic [1:0] a
   );
      return (f3[1:0] == F3_LH[1:0] && a[0])
          || (f3[1:0] == F3_LW[1:0] && a != 2'b00);
   endfunction

   function automatic logic [XLEN_BYTES-1:0] lane_mask(
      input logic [2:0] f3,
      input logic [1:0] a
   );
      logic [XLEN_BYTES-1:0] m;
      unique case (f3)
         F3_SB:   m = 4'b0001 << a;
         F3_SH:   m = a[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic [XLEN_DEF-1:0] lane_word(
      input logic [2:0]          f3,
      input logic [XLEN_DEF-1:0] sd
   );
      logic [XLEN_DEF-1:0] w;
      unique case (f3)
         F3_SB:   w = {4{sd[7:0]}};
         F3_SH:   w = {2{sd[15:0]}};
         default: w = sd;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/rattlesnake_load_store_unit_if.sv
// Execute-side request bundle plus data side of the shared
// memory port; master drives requests/memory, slave is the LSU.
interface rattlesnake_load_store_unit_if
   import rattlesnake_load_store_unit_pkg::*;
#(
   parameter int MEM_ADDR_BITS = MEM_ADDR_BITS_DEF,
   parameter int XLEN          = XLEN_DEF
) ();

   logic                     ls_start;
   logic                     ls_is_load;
   logic                     ls_is_store;
   logic [2:0]               ls_funct3;
   logic [XLEN-1:0]          ls_addr;
   logic [XLEN-1:0]          ls_store_data;
   logic                     ls_ready;

   logic                     mem_port_busy;
   logic                     mem_enable_out;
   logic [XLEN-1:0]          mem_word_out;

   logic                     data_read_enable;
   logic [XLEN/8-1:0]        data_write_enable;
   logic [MEM_ADDR_BITS-1:0] data_rw_addr;
   logic [XLEN-1:0]          data_write_word;
   logic                     data_priority_req;

   logic                     load_done;
   logic [XLEN-1:0]          load_data;
   logic                     store_done;
   logic                     exc_misaligned;
   logic                     exc_illegal;
   logic [XLEN-1:0]          exc_addr;

   modport master (
      output ls_start, ls_is_load, ls_is_store,
      output ls_funct3, ls_addr, ls_store_data,
      input  ls_ready,
      output mem_port_busy, mem_enable_out, mem_word_out,
      input  data_read_enable, data_write_enable,
      input  data_rw_addr, data_write_word,
      input  data_priority_req,
      input  load_done, load_data, store_done,
      input  exc_misaligned, exc_illegal, exc_addr
   );

   modport slave (
      input  ls_start, ls_is_load, ls_is_store,
      input  ls_funct3, ls_addr, ls_store_data,
      output ls_ready,
      input  mem_port_busy, mem_enable_out, mem_word_out,
      output data_read_enable, data_write_enable,
      output data_rw_addr, data_write_word,
      output data_priority_req,
      output load_done, load_data, store_done,
      output exc_misaligned, exc_illegal, exc_addr
   );

endinterface

// File: rtl/rattlesnake_load_align.sv
// Load return path: shift the addressed lane down and
// sign- or zero-extend it to a full register value.
module rattlesnake_load_align
   import rattlesnake_load_store_unit_pkg::*;
(
   input  logic [XLEN_DEF-1:0] word_i,
   input  logic [1:0]          off_i,
   input  logic [2:0]          funct3_i,
   output logic [XLEN_DEF-1:0] data_o
);

   logic [XLEN_DEF-1:0] sh;

   always_comb begin
      sh     = word_i >> {off_i, 3'b000};
      data_o = sh;
      unique case (funct3_i)
         F3_LB:   data_o = {{24{sh[7]}}, sh[7:0]};
         F3_LH:   data_o = {{16{sh[15]}}, sh[15:0]};
         F3_LBU:  data_o = {24'd0, sh[7:0]};
         F3_LHU:  data_o = {16'd0, sh[15:0]};
         default: data_o = sh;
      endcase
   end

endmodule

// File: rtl/rattlesnake_load_store_unit.sv
// RV32 load/store unit: byte requests in, word-addressed data
// side of the shared memory port out, aligned loads back.
module rattlesnake_load_store_unit
   import rattlesnake_load_store_unit_pkg::*;
#(
   parameter int MEM_ADDR_BITS = MEM_ADDR_BITS_DEF,
   parameter int XLEN          = XLEN_DEF,
   parameter int STARVE_CYCLES = STARVE_DEF
) (
   input logic clk,
   input logic reset_n,
   input logic sync_reset,
   rattlesnake_load_store_unit_if.slave bus
);

   localparam int CW = $clog2(STARVE_CYCLES + 1);
   localparam logic [CW-1:0] SAT = CW'(STARVE_CYCLES);

   ls_state_e state_q, state_d;

   logic                     is_load_q, is_load_d;
   logic [2:0]               f3_q, f3_d;
   logic [1:0]               off_q, off_d;
   logic [MEM_ADDR_BITS-1:0] waddr_q, waddr_d;
   logic [XLEN_BYTES-1:0]    mask_q, mask_d;
   logic [XLEN-1:0]          wword_q, wword_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [XLEN-1:0]          ldata_q, ldata_d;
   logic [XLEN-1:0]          exc_addr_q, exc_addr_d;
   logic                     ld_done_q, ld_done_d;
   logic                     st_done_q, st_done_d;
   logic                     mis_q, mis_d;
   logic                     ill_q, ill_d;

   logic            accept;
   logic            req_bad;
   logic            req_mis;
   logic            in_req;
   logic [XLEN-1:0] aligned;

   rattlesnake_load_align u_align (
      .word_i   (bus.mem_word_out),
      .off_i    (off_q),
      .funct3_i (f3_q),
      .data_o   (aligned)
   );

   assign accept = bus.ls_start
                && (state_q == S_IDLE)
                && (bus.ls_is_load || bus.ls_is_store);

   assign req_bad = bad_req(bus.ls_is_load,
                            bus.ls_is_store,
                            bus.ls_funct3);

   assign req_mis = !req_bad
                 && misaligned(bus.ls_funct3,
                               bus.ls_addr[1:0]);

   always_comb begin
      state_d    = state_q;
      is_load_d  = is_load_q;
      f3_d       = f3_q;
      off_d      = off_q;
      waddr_d    = waddr_q;
      mask_d     = mask_q;
      wword_d    = wword_q;
      cnt_d      = cnt_q;
      ldata_d    = ldata_q;
      exc_addr_d = exc_addr_q;
      ld_done_d  = 1'b0;
      st_done_d  = 1'b0;
      mis_d      = 1'b0;
      ill_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               is_load_d = bus.ls_is_load;
               f3_d      = bus.ls_funct3;
               off_d     = bus.ls_addr[1:0];
               waddr_d   = bus.ls_addr[MEM_ADDR_BITS+1:2];
               mask_d    = lane_mask(bus.ls_funct3,
                                     bus.ls_addr[1:0]);
               wword_d   = lane_word(bus.ls_funct3,
                                     bus.ls_store_data);
               cnt_d     = '0;
               ill_d     = req_bad;
               mis_d     = req_mis;
               exc_addr_d = (req_bad || req_mis)
                          ? bus.ls_addr : '0;
               // faults park in DONE so ls_ready drops for a cycle
               state_d   = (req_bad || req_mis)
                         ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (!bus.mem_port_busy) begin
               state_d   = is_load_q ? S_WAIT : S_IDLE;
               st_done_d = !is_load_q;
            end else if (cnt_q != SAT) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT: begin
            ldata_d   = aligned;
            ld_done_d = 1'b1;
            state_d   = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
      endcase

      if (sync_reset) begin
         state_d    = S_IDLE;
         is_load_d  = 1'b0;
         f3_d       = '0;
         off_d      = '0;
         waddr_d    = '0;
         mask_d     = '0;
         wword_d    = '0;
         cnt_d      = '0;
         ldata_d    = '0;
         exc_addr_d = '0;
         ld_done_d  = 1'b0;
         st_done_d  = 1'b0;
         mis_d      = 1'b0;
         ill_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         is_load_q  <= 1'b0;
         f3_q       <= '0;
         off_q      <= '0;
         waddr_q    <= '0;
         mask_q     <= '0;
         wword_q    <= '0;
         cnt_q      <= '0;
         ldata_q    <= '0;
         exc_addr_q <= '0;
         ld_done_q  <= 1'b0;
         st_done_q  <= 1'b0;
         mis_q      <= 1'b0;
         ill_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_load_q  <= is_load_d;
         f3_q       <= f3_d;
         off_q      <= off_d;
         waddr_q    <= waddr_d;
         mask_q     <= mask_d;
         wword_q    <= wword_d;
         cnt_q      <= cnt_d;
         ldata_q    <= ldata_d;
         exc_addr_q <= exc_addr_d;
         ld_done_q  <= ld_done_d;
         st_done_q  <= st_done_d;
         mis_q      <= mis_d;
         ill_q      <= ill_d;
      end
   end

   assign in_req = (state_q == S_REQ);

   assign bus.ls_ready          = (state_q == S_IDLE);
   assign bus.data_read_enable  = in_req && is_load_q;
   assign bus.data_write_enable = (in_req && !is_load_q)
                                ? mask_q : '0;
   assign bus.data_rw_addr      = in_req ? waddr_q : '0;
   assign bus.data_write_word   = (in_req && !is_load_q)
                                ? wword_q : '0;
   assign bus.data_priority_req = in_req && (cnt_q >= SAT);
   assign bus.load_done         = ld_done_q;
   assign bus.load_data         = ldata_q;
   assign bus.store_done        = st_done_q;
   assign bus.exc_misaligned    = mis_q;
   assign bus.exc_illegal       = ill_q;
   assign bus.exc_addr          = exc_addr_q;

   // read data is only captured in WAIT, so it must be valid then
   a_wait_data : assert property (
      @(posedge clk) disable iff (!reset_n || sync_reset)
      (state_q == S_WAIT) |-> bus.mem_enable_out
   );

endmodule

// File: tb/tb_rattlesnake_load_store_unit.sv
// Bench for the load/store unit: vector table, scoreboard of
// completion pulses, contention and mid-load reset sequences.
module tb_rattlesnake_load_store_unit;

  typedef enum int {EV_LOAD, EV_STORE, EV_MIS, EV_ILL} ev_e;

  typedef struct {
    ev_e         kind;
    logic [31:0] data;
    logic [31:0] addr;
    int          due;
  } exp_t;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] mem;
    ev_e         kind;
    logic [15:0] waddr;
    logic [3:0]  mask;
    logic [31:0] word;
    logic [31:0] data;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sync_reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sbq[$];
  vec_t vt[$];

  always #5 clk = ~clk;

  rattlesnake_load_store_unit_if #(
    .MEM_ADDR_BITS(16), .XLEN(32)
  ) bus ();

  rattlesnake_load_store_unit #(
    .MEM_ADDR_BITS(16), .XLEN(32), .STARVE_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sync_reset(sync_reset),
    .bus(bus)
  );

  // port returns read data the cycle after a granted read
  always @(posedge clk)
    bus.mem_enable_out <= bus.data_read_enable
                       && !bus.mem_port_busy;

  function automatic vec_t mk(
    input logic ld, input logic st, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] sd,
    input logic [31:0] mem, input ev_e kind,
    input logic [15:0] waddr, input logic [3:0] mask,
    input logic [31:0] word, input logic [31:0] data);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr;
    v.sd = sd; v.mem = mem; v.kind = kind;
    v.waddr = waddr; v.mask = mask;
    v.word = word; v.data = data;
    return v;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    end
  endtask

  task automatic observe();
    ev_e k;
    int n;
    exp_t e;
    n = int'(bus.load_done) + int'(bus.store_done)
      + int'(bus.exc_misaligned) + int'(bus.exc_illegal);
    if (n == 0) return;
    checks++;
    if (bus.load_done) k = EV_LOAD;
    else if (bus.store_done) k = EV_STORE;
    else if (bus.exc_misaligned) k = EV_MIS;
    else k = EV_ILL;
    if (n > 1) begin
      failures++;
      $display("FAIL pulse_count: got %0d expected 1", n);
      return;
    end
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL unexpected_pulse: got %s cyc=%0d expected none",
               k.name(), cyc);
      return;
    end
    e = sbq.pop_front();
    if (k != e.kind || cyc != e.due
        || (k == EV_LOAD && bus.load_data !== e.data)
        || ((k == EV_MIS || k == EV_ILL)
            && bus.exc_addr !== e.addr)) begin
      failures++;
      $display({"FAIL completion: got %s cyc=%0d data=0x%08h ",
                "exc_addr=0x%08h expected %s cyc=%0d ",
                "data=0x%08h exc_addr=0x%08h"},
               k.name(), cyc, bus.load_data, bus.exc_addr,
               e.kind.name(), e.due, e.data, e.addr);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    observe();
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sbq.size() == 0 && bus.ls_ready) break;
      tick();
    end
    checks++;
    if (sbq.size() != 0 || !bus.ls_ready) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               sbq.size());
      sbq.delete();
    end
  endtask

  task automatic drive(input vec_t v);
    bus.ls_start      = 1'b1;
    bus.ls_is_load    = v.ld;
    bus.ls_is_store   = v.st;
    bus.ls_funct3     = v.f3;
    bus.ls_addr       = v.addr;
    bus.ls_store_data = v.sd;
    bus.mem_word_out  = v.mem;
  endtask

  task automatic push(input vec_t v, input int extra);
    exp_t e;
    int lat;
    lat = (v.kind == EV_LOAD) ? 2 : (v.kind == EV_STORE) ? 1 : 0;
    e.kind = v.kind;
    e.data = v.data;
    e.addr = v.addr;
    e.due  = cyc + 1 + lat + extra;
    sbq.push_back(e);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic ok;
    ok = (v.kind == EV_LOAD || v.kind == EV_STORE);
    drive(v);
    push(v, 0);
    tick();
    bus.ls_start = 1'b0;
    check($sformatf("v%0d_rd", idx),
          32'(bus.data_read_enable), 32'(v.kind == EV_LOAD));
    check($sformatf("v%0d_addr", idx),
          32'(bus.data_rw_addr), ok ? 32'(v.waddr) : 32'd0);
    check($sformatf("v%0d_mask", idx),
          32'(bus.data_write_enable),
          (v.kind == EV_STORE) ? 32'(v.mask) : 32'd0);
    check($sformatf("v%0d_word", idx), bus.data_write_word,
          (v.kind == EV_STORE) ? v.word : 32'd0);
    check($sformatf("v%0d_ready", idx),
          32'(bus.ls_ready), 32'd0);
    drain();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, 32'(bus.ls_ready), 32'd1);
    check({tag, "_pulses"},
          {bus.load_done, bus.store_done,
           bus.exc_misaligned, bus.exc_illegal}, 32'd0);
    check({tag, "_rd"}, 32'(bus.data_read_enable), 32'd0);
    check({tag, "_mask"}, 32'(bus.data_write_enable), 32'd0);
    check({tag, "_addr"}, 32'(bus.data_rw_addr), 32'd0);
    check({tag, "_prio"}, 32'(bus.data_priority_req), 32'd0);
    check({tag, "_ldata"}, bus.load_data, 32'd0);
    check({tag, "_eaddr"}, bus.exc_addr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t lw;
    bus.ls_start      = 1'b0;
    bus.ls_is_load    = 1'b0;
    bus.ls_is_store   = 1'b0;
    bus.ls_funct3     = 3'd0;
    bus.ls_addr       = 32'd0;
    bus.ls_store_data = 32'd0;
    bus.mem_port_busy = 1'b0;
    bus.mem_word_out  = 32'd0;

    vt.push_back(mk(1,0,3'd2,32'h104,0,32'hDEADBEEF,
                    EV_LOAD,16'h41,0,0,32'hDEADBEEF));
    vt.push_back(mk(1,0,3'd0,32'h103,0,32'h80FF7F01,
                    EV_LOAD,16'h40,0,0,32'hFFFFFF80));
    vt.push_back(mk(1,0,3'd4,32'h103,0,32'h80FF7F01,
                    EV_LOAD,16'h40,0,0,32'h00000080));
    vt.push_back(mk(1,0,3'd1,32'h102,0,32'h80FF7F01,
                    EV_LOAD,16'h40,0,0,32'hFFFF80FF));
    vt.push_back(mk(1,0,3'd5,32'h102,0,32'h80FF7F01,
                    EV_LOAD,16'h40,0,0,32'h000080FF));
    vt.push_back(mk(1,0,3'd0,32'h101,0,32'h80FF7F01,
                    EV_LOAD,16'h40,0,0,32'h0000007F));
    vt.push_back(mk(1,0,3'd1,32'h100,0,32'h80FF7F01,
                    EV_LOAD,16'h40,0,0,32'h00007F01));
    vt.push_back(mk(1,0,3'd2,32'hFFFC0104,0,32'h12345678,
                    EV_LOAD,16'h41,0,0,32'h12345678));
    vt.push_back(mk(0,1,3'd0,32'h201,32'h000000A5,0,
                    EV_STORE,16'h80,4'b0010,32'hA5A5A5A5,0));
    vt.push_back(mk(0,1,3'd0,32'h203,32'h1234565A,0,
                    EV_STORE,16'h80,4'b1000,32'h5A5A5A5A,0));
    vt.push_back(mk(0,1,3'd1,32'h206,32'h1234BEEF,0,
                    EV_STORE,16'h81,4'b1100,32'hBEEFBEEF,0));
    vt.push_back(mk(0,1,3'd1,32'h200,32'h1234BEEF,0,
                    EV_STORE,16'h80,4'b0011,32'hBEEFBEEF,0));
    vt.push_back(mk(0,1,3'd2,32'h208,32'hCAFEF00D,0,
                    EV_STORE,16'h82,4'b1111,32'hCAFEF00D,0));
    vt.push_back(mk(0,1,3'd2,32'h102,32'h11111111,0,
                    EV_MIS,0,0,0,0));
    vt.push_back(mk(1,0,3'd1,32'h101,0,0,EV_MIS,0,0,0,0));
    vt.push_back(mk(1,0,3'd2,32'h106,0,0,EV_MIS,0,0,0,0));
    vt.push_back(mk(1,0,3'd5,32'h303,0,0,EV_MIS,0,0,0,0));
    vt.push_back(mk(1,1,3'd2,32'h301,0,0,EV_ILL,0,0,0,0));
    vt.push_back(mk(1,0,3'd3,32'h300,0,0,EV_ILL,0,0,0,0));
    vt.push_back(mk(1,0,3'd6,32'h304,0,0,EV_ILL,0,0,0,0));
    vt.push_back(mk(1,0,3'd7,32'h308,0,0,EV_ILL,0,0,0,0));
    vt.push_back(mk(0,1,3'd4,32'h30C,0,0,EV_ILL,0,0,0,0));
    vt.push_back(mk(0,1,3'd3,32'h310,0,0,EV_ILL,0,0,0,0));

    tick();
    tick();
    check_quiet("reset");
    reset_n = 1'b1;
    tick();

    foreach (vt[i]) run_vec(vt[i], i);

    // neither load nor store: strobe ignored
    bus.ls_start = 1'b1;
    bus.ls_is_load = 1'b0;
    bus.ls_is_store = 1'b0;
    tick();
    bus.ls_start = 1'b0;
    check("none_ready", 32'(bus.ls_ready), 32'd1);
    check("none_rd", 32'(bus.data_read_enable), 32'd0);
    tick();

    // contended load: 10 busy cycles, stray strobe in REQ
    lw = vt[0];
    bus.mem_port_busy = 1'b1;
    drive(lw);
    push(lw, 10);
    tick();
    bus.ls_start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      check($sformatf("busy%0d_rd", k),
            32'(bus.data_read_enable), 32'd1);
      check($sformatf("busy%0d_addr", k),
            32'(bus.data_rw_addr), 32'h41);
      check($sformatf("busy%0d_prio", k),
            32'(bus.data_priority_req), 32'(k >= 8));
      if (k == 3) begin
        bus.ls_start = 1'b1;
        bus.ls_is_load = 1'b0;
        bus.ls_is_store = 1'b1;
        bus.ls_funct3 = 3'd2;
        bus.ls_addr = 32'h400;
      end else begin
        bus.ls_start = 1'b0;
      end
      if (k == 10) bus.mem_port_busy = 1'b0;
      tick();
    end
    check("grant_prio", 32'(bus.data_priority_req), 32'd0);
    check("grant_rd", 32'(bus.data_read_enable), 32'd0);
    drain();

    // async reset while the load waits for data
    drive(lw);
    tick();
    bus.ls_start = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check_quiet("areset");
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("areset_post%0d", i),
            {bus.ls_ready, bus.load_done}, 32'b10);
    end

    // same with the synchronous reset
    drive(lw);
    tick();
    bus.ls_start = 1'b0;
    tick();
    sync_reset = 1'b1;
    tick();
    check_quiet("sreset");
    sync_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sreset_post%0d", i),
            {bus.ls_ready, bus.load_done}, 32'b10);
    end

    // unit still works after both resets
    run_vec(vt[1], 100);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
